fp_uart_rx: RTL and testbench

// - UART receiver, 8N1 (optionally 8E1), into a small byte FIFO with a ready/valid output.
// - Serves the bootloader and host link: the serial line in, the byte stream toward the core-side consumer.
// - Receive counterpart of the FlexPRET UART TX; runs on the board system clock.

---
 rtl/fp_uart_pkg.sv | 21 ++
 rtl/fp_uart_rx_fifo.sv | 86 ++++++++
 rtl/fp_uart_rx.sv | 206 ++++++++++++++++++++
 tb/tb_fp_uart_rx.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_uart_pkg.sv
// Shared UART definitions for the FlexPRET UART receive and transmit blocks.
// Holds the receiver state encoding, the frame data width and a parity helper.
package fp_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    // XOR-reduction of a data byte: 1 when the byte holds an odd number of ones.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/fp_uart_rx_fifo.sv
// Receive byte FIFO, first-word-fall-through.
// The head byte is kept in a register that is refreshed whenever the FIFO will be
// non-empty after the current edge, so it holds the last head once the FIFO drains.
// A push while full is taken only when a pop happens in the same cycle.
module fp_uart_rx_fifo
    import fp_uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] push_data,
    input  logic                      pop,
    output logic                      full,
    output logic                      empty,
    output logic [UART_DATA_BITS-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ZERO_COUNT = (AW+1)'(0);

    logic [UART_DATA_BITS-1:0] mem_r [DEPTH];
    logic [AW-1:0]             wr_ptr_r;
    logic [AW-1:0]             rd_ptr_r;
    logic [AW-1:0]             rd_ptr_n_s;
    logic [AW:0]               count_r;
    logic [AW:0]               count_n_s;
    logic [UART_DATA_BITS-1:0] head_r;
    logic                      do_push_s;
    logic                      do_pop_s;

    assign full  = (count_r == FULL_COUNT);
    assign empty = (count_r == ZERO_COUNT);
    assign head  = head_r;

    // Decide which push/pop actually commit and the resulting read pointer/count.
    always_comb begin
        do_pop_s   = pop & ~empty;
        do_push_s  = push & (~full | do_pop_s);
        rd_ptr_n_s = do_pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        count_n_s  = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_n_s = count_r + (AW+1)'(1);
            2'b01:   count_n_s = count_r - (AW+1)'(1);
            default: count_n_s = count_r;
        endcase
    end

    // Storage array write port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r <= rd_ptr_n_s;
            count_r  <= count_n_s;
        end
    end

    // Head register: bypass the incoming byte when it becomes the only entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_r <= '0;
        end else if (count_n_s != ZERO_COUNT) begin
            head_r <= (do_push_s && (wr_ptr_r == rd_ptr_n_s)) ? push_data : mem_r[rd_ptr_n_s];
        end
    end

endmodule

// File: rtl/fp_uart_rx.sv
// FlexPRET UART receiver: 8N1 frames (8E1 when UART_RX_PARITY_EN is defined)
// decoded from the synchronised serial line into a ready/valid byte FIFO.
// The start bit is qualified at its midpoint; every later bit is sampled DIV
// clocks after the previous one, i.e. near its centre.
module fp_uart_rx
    import fp_uart_pkg::*;
#(
    parameter int DIV        = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      valid,
    input  logic                      ready,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      busy
);

    localparam int            CW       = $clog2(DIV);
    localparam logic [CW-1:0] CNT_TOP  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

    logic                      sync1_r;
    logic                      rs_r;
    rx_state_t                 state_r;
    rx_state_t                 state_n_s;
    logic [CW-1:0]             cnt_r;
    logic [CW-1:0]             cnt_n_s;
    logic [2:0]                idx_r;
    logic [2:0]                idx_n_s;
    logic [UART_DATA_BITS-1:0] shift_r;
    logic [UART_DATA_BITS-1:0] shift_n_s;
    logic                      push_r;
    logic                      push_n_s;
    logic                      frame_err_r;
    logic                      frame_err_n_s;
    logic                      busy_r;
    logic                      parity_ok_s;
    logic                      fifo_full_s;
    logic                      fifo_empty_s;
`ifdef UART_RX_PARITY_EN
    logic                      par_r;
    logic                      par_n_s;
`endif

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            rs_r    <= 1'b1;
        end else begin
            sync1_r <= rx;
            rs_r    <= sync1_r;
        end
    end

    // Receiver state, bit timing and registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            idx_r       <= 3'd0;
            shift_r     <= '0;
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_n_s;
            cnt_r       <= cnt_n_s;
            idx_r       <= idx_n_s;
            shift_r     <= shift_n_s;
            push_r      <= push_n_s;
            frame_err_r <= frame_err_n_s;
            busy_r      <= (state_n_s != IDLE);
`ifdef UART_RX_PARITY_EN
            par_r       <= par_n_s;
`endif
        end
    end

    // Next-state logic: bit sampling, framing and parity decisions.
    always_comb begin
        state_n_s     = state_r;
        cnt_n_s       = cnt_r;
        idx_n_s       = idx_r;
        shift_n_s     = shift_r;
        push_n_s      = 1'b0;
        frame_err_n_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n_s       = par_r;
        parity_ok_s   = ((even_parity(shift_r) ^ par_r) == 1'b0);
`else
        parity_ok_s   = 1'b1;
`endif
        case (state_r)
            IDLE: begin
                if (!rs_r) begin
                    state_n_s = START;
                    cnt_n_s   = CNT_HALF;
                end else begin
                    state_n_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == CNT_ZERO) begin
                    if (rs_r) begin
                        // Line back high at mid start bit: treat as a glitch.
                        state_n_s = IDLE;
                    end else begin
                        state_n_s = DATA;
                        cnt_n_s   = CNT_TOP;
                        idx_n_s   = 3'd0;
                    end
                end else begin
                    cnt_n_s = cnt_r - CW'(1);
                end
            end
            DATA: begin
                if (cnt_r == CNT_ZERO) begin
                    shift_n_s = {rs_r, shift_r[UART_DATA_BITS-1:1]};
                    cnt_n_s   = CNT_TOP;
                    if (idx_r == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_n_s = PARITY;
`else
                        state_n_s = STOP;
`endif
                    end else begin
                        idx_n_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_n_s = cnt_r - CW'(1);
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (cnt_r == CNT_ZERO) begin
                    par_n_s   = rs_r;
                    state_n_s = STOP;
                    cnt_n_s   = CNT_TOP;
                end else begin
                    cnt_n_s = cnt_r - CW'(1);
                end
`else
                // Unreachable without parity support; recover to IDLE.
                state_n_s = IDLE;
`endif
            end
            STOP: begin
                if (cnt_r == CNT_ZERO) begin
                    if (!rs_r) begin
                        // Bad stop (with or without bad parity): one pulse, wait for line high.
                        frame_err_n_s = 1'b1;
                        state_n_s     = BREAK;
                    end else if (!parity_ok_s) begin
                        frame_err_n_s = 1'b1;
                        state_n_s     = IDLE;
                    end else begin
                        push_n_s  = 1'b1;
                        state_n_s = IDLE;
                    end
                end else begin
                    cnt_n_s = cnt_r - CW'(1);
                end
            end
            BREAK: begin
                if (rs_r) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = BREAK;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    fp_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_r),
        .push_data (shift_r),
        .pop       (ready),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (data_out)
    );

    assign valid     = ~fifo_empty_s;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;
    // A byte is lost only if the FIFO is full and no pop frees a slot in the push cycle.
    assign overrun   = push_r & fifo_full_s & ~(ready & ~fifo_empty_s);

endmodule

// File: tb/tb_fp_uart_rx.sv
// Self-checking bench for fp_uart_rx with DIV=8 and an 8-entry FIFO.
// Define UART_RX_PARITY_EN for both bench and RTL to exercise 8E1 frames.
`timescale 1ns/1ps
module tb_fp_uart_rx;

    localparam int DIV = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic       ready;
    logic       ready_d;
    logic       rnd_rdy;
    logic       rand_en;
    logic       sb_en;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         errors = 0;
    int         checks = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [7:0] exp_q[$];
    logic       fe_s1;
    logic       ov_s1;
    logic       val_s1;

    always #5 clock = ~clock;

    assign ready = rand_en ? rnd_rdy : ready_d;

    fp_uart_rx #(
        .DIV        (DIV),
        .FIFO_DEPTH (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse counters and handshake scoreboard, sampled mid-cycle.
    always @(negedge clock) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if ((frame_err | overrun) === 1'b1) check_eq("pulse_excl", frame_err & overrun, 1'b0);
        if (sb_en && valid && ready) begin
            if (exp_q.size() == 0) check_eq("sb_unexpected_byte", 32'(data_out) | 32'h100, 32'h0);
            else check_eq("sb_data", data_out, exp_q.pop_front());
        end
    end

    // Random consumer readiness, changed just after each rising edge.
    initial begin
        rnd_rdy = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            rnd_rdy = 1'($urandom_range(1, 0));
        end
    end

    // Drive one frame; called just after a rising edge. Returns just after the
    // rising edge that ends cycle S+1, having sampled the S+1 outputs.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic par_flip, input logic pop_at_push);
        rx = 1'b0;
        repeat (DIV) @(posedge clock);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (DIV) @(posedge clock);
            #1;
        end
        if (PAR_EN) begin
            rx = (^d) ^ par_flip;
            repeat (DIV) @(posedge clock);
            #1;
        end
        rx = stop_bit;
        repeat (DIV - 2) @(posedge clock);
        #1;
        @(negedge clock);
        @(posedge clock);
        #1;
        if (pop_at_push) ready_d = 1'b1;
        @(negedge clock);
        fe_s1  = frame_err;
        ov_s1  = overrun;
        val_s1 = valid;
        @(posedge clock);
        #1;
        if (pop_at_push) ready_d = 1'b0;
    endtask

    // Pop n bytes, each checked against the expected queue, then expect empty.
    task automatic drain(input int n);
        ready_d = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check_eq("drain_valid", valid, 1'b1);
            check_eq("drain_data", data_out, exp_q.pop_front());
        end
        @(posedge clock);
        #1;
        ready_d = 1'b0;
        @(negedge clock);
        check_eq("drain_empty", valid, 1'b0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int         f0;
        int         o0;
        int         nbad;
        logic [7:0] d;
        logic       bad;

        reset   = 1'b0;
        rx      = 1'b1;
        ready_d = 1'b0;
        rand_en = 1'b0;
        sb_en   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_data_out", data_out, 8'h00);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_frame_err", frame_err, 1'b0);
        check_eq("rst_overrun", overrun, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        reset = 1'b1;
        repeat (5) @(posedge clock);
        #1;

        // Single frame 0xA5: valid appears at S+2 and falls after one pop.
        f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check_eq("a5_valid_s1", val_s1, 1'b0);
        check_eq("a5_fe_s1", fe_s1, 1'b0);
        @(negedge clock);
        check_eq("a5_valid_s2", valid, 1'b1);
        check_eq("a5_data", data_out, 8'hA5);
        @(posedge clock); #1; ready_d = 1'b1;
        @(posedge clock); #1; ready_d = 1'b0;
        @(negedge clock);
        check_eq("a5_valid_after_pop", valid, 1'b0);
        check_eq("a5_data_hold", data_out, 8'hA5);
        check_eq("a5_no_pulses", (fe_cnt - f0) + (ov_cnt - o0), 0);
        @(posedge clock); #1;

        // Back-to-back frames with no consumer.
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        check_eq("b2b_busy_gap1", busy, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        check_eq("b2b_busy_gap2", busy, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h3C);
        drain(3);

        // Start-bit glitch.
        f0 = fe_cnt;
        rx = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        rx = 1'b1;
        @(negedge clock);
        check_eq("glitch_busy", busy, 1'b1);
        repeat (20) @(posedge clock);
        #1;
        check_eq("glitch_idle", busy, 1'b0);
        check_eq("glitch_valid", valid, 1'b0);
        check_eq("glitch_fe", fe_cnt - f0, 0);

        // Bad stop bit followed by a long break.
        f0 = fe_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        check_eq("brk_fe_s1", fe_s1, 1'b1);
        repeat (20 * DIV) @(posedge clock);
        #1;
        check_eq("brk_busy", busy, 1'b1);
        check_eq("brk_fe_count", fe_cnt - f0, 1);
        check_eq("brk_valid", valid, 1'b0);
        rx = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check_eq("brk_release", busy, 1'b0);

        // Fill the FIFO, then a 9th byte without and with a same-cycle pop.
        o0 = ov_cnt;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 8; i++) begin
                d = 8'($urandom);
                exp_q.push_back(d);
                send_frame(d, 1'b1, 1'b0, 1'b0);
            end
            d = 8'($urandom);
            send_frame(d, 1'b1, 1'b0, pass == 1);
            check_eq("ovr_pulse", ov_s1, (pass == 0) ? 1'b1 : 1'b0);
            check_eq("ovr_no_fe", fe_s1, 1'b0);
            if (pass == 1) begin
                void'(exp_q.pop_front());
                exp_q.push_back(d);
            end
            @(negedge clock);
            check_eq("ovr_head", data_out, exp_q[0]);
            @(posedge clock); #1;
            drain(8);
        end
        check_eq("ovr_total", ov_cnt - o0, 1);

        // Reset in the middle of a frame, then a clean frame.
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (DIV) @(posedge clock);
        #1;
        rx = 1'b1;
        repeat (DIV + 4) @(posedge clock);
        #3;
        check_eq("mid_busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_data", data_out, 8'h00);
        check_eq("mid_rst_valid", valid, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_fe", frame_err, 1'b0);
        check_eq("mid_rst_ov", overrun, 1'b0);
        rx = 1'b1;
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'h81);
        drain(1);

        if (PAR_EN) begin
            f0 = fe_cnt;
            send_frame(8'h03, 1'b1, 1'b0, 1'b0);
            check_eq("par_good_fe", fe_s1, 1'b0);
            exp_q.push_back(8'h03);
            drain(1);
            send_frame(8'h03, 1'b1, 1'b1, 1'b0);
            check_eq("par_bad_fe", fe_s1, 1'b1);
            repeat (4) @(posedge clock);
            #1;
            check_eq("par_bad_nopush", valid, 1'b0);
            check_eq("par_fe_count", fe_cnt - f0, 1);
        end

        // Random traffic with a random consumer, checked by the scoreboard.
        f0 = fe_cnt; o0 = ov_cnt; nbad = 0;
        rand_en = 1'b1;
        sb_en   = 1'b1;
        for (int n = 0; n < 16; n++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(5, 0) == 0);
            send_frame(d, ~bad, 1'b0, 1'b0);
            if (bad) begin
                nbad++;
                repeat ($urandom_range(20, 1)) @(posedge clock);
                #1;
                rx = 1'b1;
            end else begin
                exp_q.push_back(d);
            end
            repeat ($urandom_range(15, 0)) @(posedge clock);
            #1;
        end
        for (int w = 0; w < 500 && exp_q.size() != 0; w++) @(posedge clock);
        #1;
        check_eq("rand_drained", exp_q.size(), 0);
        check_eq("rand_fe_count", fe_cnt - f0, nbad);
        check_eq("rand_no_overrun", ov_cnt - o0, 0);
        rand_en = 1'b0;
        sb_en   = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
